pll_phase_stepper: RTL and testbench

//  Drives the EHXPLLL dynamic phase-adjust interface (PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG).

---
 rtl/pll_phase_stepper_if.sv | 25 ++
 rtl/pll_phase_stepper.sv | 195 +++++++++++++++++++
 tb/tb_pll_phase_stepper.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_stepper_if.sv
// System-side request/status bundle for pll_phase_stepper.
// The master drives the step requests and the slave is the stepper.
interface pll_phase_stepper_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_sel;
  logic             req_dir;
  logic             req_load;
  logic [CNT_W-1:0] req_steps;
  logic             busy;
  logic             done;
  logic             abort;

  modport master (
    output req_valid, req_sel, req_dir, req_load, req_steps,
    input  req_ready, busy, done, abort
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_load, req_steps,
    output req_ready, busy, done, abort
  );
endinterface

// File: rtl/pll_phase_stepper.sv
// Timed, lock-qualified driver for the EHXPLLL dynamic phase-adjust pins.
// Define PLL_PHASE_TRACK_EN to add per-output fine-phase position trackers.
module pll_phase_stepper #(
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned STEP_LOW_CYC = 4,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned LOCK_SYNC    = 2,
  parameter int unsigned PHASE_STEPS  = 56
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked,
  pll_phase_stepper_if.slave    bus,
  output logic [1:0]            phase_sel,
  output logic                  phase_dir,
  output logic                  phase_step,
  output logic                  phase_loadreg,
  output logic [7:0]            phase_pos
);

  localparam int unsigned TMR_MAX =
      (SETUP_CYC > STEP_LOW_CYC) ?
        ((SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC) :
        ((STEP_LOW_CYC > SETTLE_CYC) ? STEP_LOW_CYC : SETTLE_CYC);
  localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StSettle, StDone} state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               load_q, load_d;
  logic               step_q, step_d;
  logic               ldreg_q, ldreg_d;
  logic               abort_q, abort_d;
  logic [LOCK_SYNC-1:0] sync_q;
  logic               lock_s;
  logic               step_done;
  logic               load_done;

  assign lock_s = sync_q[LOCK_SYNC-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LOCK_SYNC-2:0], locked};
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    load_d    = load_q;
    abort_d   = 1'b0;
    step_done = 1'b0;
    load_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (lock_s && bus.req_valid) begin
          state_d = StSetup;
          tmr_d   = TMR_W'(SETUP_CYC - 1);
          sel_d   = bus.req_sel;
          dir_d   = bus.req_dir;
          load_d  = bus.req_load;
          cnt_d   = bus.req_steps;
        end
      end
      StSetup, StPulse, StSettle: begin
        if (!lock_s) begin
          // Lock loss kills the request; the active line returns high via step_d/ldreg_d.
          state_d = StIdle;
          abort_d = 1'b1;
          cnt_d   = '0;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else begin
          case (state_q)
            StSetup: begin
              if (!load_q && cnt_q == '0) begin
                state_d = StDone;
              end else begin
                state_d = StPulse;
                tmr_d   = TMR_W'(STEP_LOW_CYC - 1);
              end
            end
            StPulse: begin
              state_d   = StSettle;
              tmr_d     = TMR_W'(SETTLE_CYC - 1);
              cnt_d     = load_q ? '0 : cnt_q - CNT_W'(1);
              step_done = !load_q;
            end
            default: begin
              if (cnt_q != '0) begin
                state_d = StPulse;
                tmr_d   = TMR_W'(STEP_LOW_CYC - 1);
              end else begin
                state_d   = StDone;
                load_done = load_q;
              end
            end
          endcase
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    step_d  = !((state_d == StPulse) && !load_q);
    ldreg_d = !((state_d == StPulse) && load_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      dir_q   <= 1'b0;
      load_q  <= 1'b0;
      step_q  <= 1'b1;
      ldreg_q <= 1'b1;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      step_q  <= step_d;
      ldreg_q <= ldreg_d;
      abort_q <= abort_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle) && lock_s;
  // The abort cycle is already IDLE but still counts as busy.
  assign bus.busy      = (state_q != StIdle) || abort_q;
  assign bus.done      = (state_q == StDone);
  assign bus.abort     = abort_q;
  assign phase_sel     = sel_q;
  assign phase_dir     = dir_q;
  assign phase_step    = step_q;
  assign phase_loadreg = ldreg_q;

`ifdef PLL_PHASE_TRACK_EN
  logic [7:0] trk_q [4];
  logic [7:0] trk_d [4];

  function automatic logic [7:0] trk_next(input logic [7:0] v, input logic up);
    logic [7:0] r;
    if (up) begin
      r = (v == 8'(PHASE_STEPS - 1)) ? 8'd0 : v + 8'd1;
    end else begin
      r = (v == 8'd0) ? 8'(PHASE_STEPS - 1) : v - 8'd1;
    end
    return r;
  endfunction

  always_comb begin
    trk_d = trk_q;
    if (step_done) begin
      trk_d[sel_q] = trk_next(trk_q[sel_q], dir_q);
    end
    if (load_done) begin
      trk_d[sel_q] = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        trk_q[i] <= 8'd0;
      end
    end else begin
      trk_q <= trk_d;
    end
  end

  assign phase_pos = trk_q[bus.req_sel];
`else
  assign phase_pos = 8'd0;
`endif

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Randomised bench for pll_phase_stepper: timeline model of each request plus directed cases.
// Honours PLL_PHASE_TRACK_EN the same way as the design.
module tb_pll_phase_stepper;
  localparam int SU = 4;
  localparam int LO = 4;
  localparam int SE = 16;
  localparam int PER = LO + SE;
  localparam int PS = 56;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic [1:0] phase_sel;
  logic       phase_dir;
  logic       phase_step;
  logic       phase_loadreg;
  logic [7:0] phase_pos;

  pll_phase_stepper_if #(.CNT_W(8)) bus ();

  pll_phase_stepper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .locked        (locked),
    .bus           (bus),
    .phase_sel     (phase_sel),
    .phase_dir     (phase_dir),
    .phase_step    (phase_step),
    .phase_loadreg (phase_loadreg),
    .phase_pos     (phase_pos)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Model: a request accepted at edge a is a fixed timeline of offsets o = edge - a.
  bit         m_act, m_ld, m_dir, s1, s2, ab, dn, inr, win, acc;
  int         m_a, m_n, m_end, o;
  logic [1:0] m_sel;
  int         trk [4];
  logic       e_ready, e_busy, e_done, e_abort, e_step, e_ldreg, e_dir;
  logic [1:0] e_sel;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_act = 0; s1 = 0; s2 = 0; m_sel = 2'b00; m_dir = 0; m_ld = 0;
        for (int i = 0; i < 4; i++) trk[i] = 0;
        e_ready = 0; e_busy = 0; e_done = 0; e_abort = 0;
        e_step = 1; e_ldreg = 1; e_sel = 2'b00; e_dir = 0;
      end else begin
        ab = 0;
        dn = 0;
        acc = e_ready && bus.req_valid;
        if (m_act) begin
          o = cyc - m_a;
          if (o >= 1 && o <= m_end && !s2) begin
            ab = 1;
            m_act = 0;
          end else begin
            if (!m_ld && o >= SU + LO && (o - SU - LO) % PER == 0 && (o - SU - LO) / PER < m_n)
              trk[m_sel] = m_dir ? (trk[m_sel] + 1) % PS : (trk[m_sel] + PS - 1) % PS;
            if (o == m_end) begin
              dn = 1;
              if (m_ld) trk[m_sel] = 0;
            end
            if (o == m_end + 1) m_act = 0;
          end
        end
        if (acc) begin
          m_act = 1;
          m_a   = cyc;
          m_sel = bus.req_sel;
          m_dir = bus.req_dir;
          m_ld  = bus.req_load;
          m_n   = bus.req_load ? 1 : int'(bus.req_steps);
          m_end = SU + PER * m_n;
        end
        s2 = s1;
        s1 = locked;
        o   = cyc - m_a;
        inr = m_act && o <= m_end;
        win = inr && o >= SU && (o - SU) % PER < LO && (o - SU) / PER < m_n;
        e_busy  = inr || ab;
        e_done  = dn;
        e_abort = ab;
        e_step  = !(win && !m_ld);
        e_ldreg = !(win && m_ld);
        e_ready = !m_act && s2;
        e_sel   = m_sel;
        e_dir   = m_dir;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        check("req_ready", bus.req_ready, e_ready);
        check("busy", bus.busy, e_busy);
        check("done", bus.done, e_done);
        check("abort", bus.abort, e_abort);
        check("phase_step", phase_step, e_step);
        check("phase_loadreg", phase_loadreg, e_ldreg);
        check("phase_sel", phase_sel, e_sel);
        check("phase_dir", phase_dir, e_dir);
`ifdef PLL_PHASE_TRACK_EN
        check("phase_pos", phase_pos, trk[bus.req_sel]);
`else
        check("phase_pos", phase_pos, 0);
`endif
      end
    end
  end

  // Per-request measurements from the last run_req call.
  int r_busy, r_falls, r_first_fall, r_step_low, r_ld_low, r_done_off;
  bit r_done, r_abort;

  task automatic run_req(input logic [1:0] sel, input logic dir, input logic ld,
                         input logic [7:0] steps, input int drop_at, input int drop_len);
    int a, n, off;
    logic prev;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    bus.req_dir   = dir;
    bus.req_load  = ld;
    bus.req_steps = steps;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      timeout("accept");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    a = cyc;
    bus.req_valid = 1'b0;
    // Scramble request fields while busy; they must be ignored.
    bus.req_sel   = 2'($urandom);
    bus.req_dir   = 1'($urandom);
    bus.req_load  = 1'($urandom);
    bus.req_steps = 8'($urandom);
    r_busy = 0; r_falls = 0; r_first_fall = -1; r_step_low = 0; r_ld_low = 0;
    r_done_off = -1; r_done = 0; r_abort = 0;
    prev = 1'b1;
    forever begin
      off = cyc - a;
      if (drop_at >= 0 && off == drop_at) locked = 1'b0;
      if (drop_at >= 0 && off == drop_at + drop_len) locked = 1'b1;
      if (bus.busy) r_busy++;
      if (!phase_step) r_step_low++;
      if (prev && !phase_step) begin
        r_falls++;
        if (r_first_fall < 0) r_first_fall = off;
      end
      prev = phase_step;
      if (!phase_loadreg) r_ld_low++;
      if (bus.done) begin
        r_done = 1;
        r_done_off = off;
      end
      if (bus.abort) r_abort = 1;
      if (!bus.busy && (drop_at < 0 || off > drop_at + drop_len)) break;
      if (off > 6000) begin
        timeout("request_end");
        break;
      end
      @(negedge clk);
    end
    locked = 1'b1;
  endtask

  task automatic check_pos(input logic [1:0] sel, input int exp_trk, input string name);
    @(negedge clk);
    bus.req_sel = sel;
    #1;
`ifdef PLL_PHASE_TRACK_EN
    check(name, phase_pos, exp_trk);
`else
    check(name, phase_pos, exp_trk * 0);
`endif
  endtask

  initial begin
    int n, steps, nn, span;
    bus.req_valid = 1'b0;
    bus.req_sel   = 2'b00;
    bus.req_dir   = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_steps = 8'd0;
    locked = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_phase_step", phase_step, 1);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // T1: three steps on CLKOS2.
    run_req(2'b01, 1'b1, 1'b0, 8'd3, -1, 0);
    check("t1_falls", r_falls, 3);
    check("t1_low_cycles", r_step_low, 12);
    check("t1_first_fall", r_first_fall, 4);
    check("t1_done_off", r_done_off, 64);
    check_pos(2'b01, 3, "t1_pos");

    // T2: zero steps.
    run_req(2'b10, 1'b0, 1'b0, 8'd0, -1, 0);
    check("t2_falls", r_falls, 0);
    check("t2_done_off", r_done_off, 4);
    check("t2_busy_cycles", r_busy, 5);

    // T3: move CLKOP tracker, then load clears it.
    run_req(2'b11, 1'b1, 1'b0, 8'd2, -1, 0);
    check_pos(2'b11, 2, "t3_pre_pos");
    run_req(2'b11, 1'b0, 1'b1, 8'd9, -1, 0);
    check("t3_ld_low", r_ld_low, 4);
    check("t3_step_low", r_step_low, 0);
    check("t3_done_off", r_done_off, 24);
    check_pos(2'b11, 0, "t3_pos");

    // T4: lock lost during third pulse.
    run_req(2'b10, 1'b1, 1'b0, 8'd5, 44, 10);
    check("t4_abort", r_abort, 1);
    check("t4_done", r_done, 0);
    check("t4_step_low", r_step_low, 11);
    check_pos(2'b10, 2, "t4_pos");

    // T5: wrap below zero and back.
    run_req(2'b00, 1'b0, 1'b0, 8'd1, -1, 0);
    check_pos(2'b00, 55, "t5_pos_dn");
    run_req(2'b00, 1'b1, 1'b0, 8'd2, -1, 0);
    check_pos(2'b00, 1, "t5_pos_up");

    // T6: reset in the middle of a pulse.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'b01;
    bus.req_dir   = 1'b1;
    bus.req_load  = 1'b0;
    bus.req_steps = 8'd3;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("t6_accept");
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (phase_step !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("t6_pulse");
    rst_n = 1'b0;
    #1;
    check("t6_ready", bus.req_ready, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_done", bus.done, 0);
    check("t6_abort", bus.abort, 0);
    check("t6_sel", phase_sel, 0);
    check("t6_dir", phase_dir, 0);
    check("t6_step", phase_step, 1);
    check("t6_loadreg", phase_loadreg, 1);
    check("t6_pos", phase_pos, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_req(2'b01, 1'b0, 1'b0, 8'd1, -1, 0);
    check("t6_new_done_off", r_done_off, 24);
    check("t6_new_falls", r_falls, 1);
    check_pos(2'b01, 55, "t6_new_pos");

    // Maximum count.
    run_req(2'b10, 1'b0, 1'b0, 8'hff, -1, 0);
    check("max_falls", r_falls, 255);
    check("max_done_off", r_done_off, SU + 255 * PER);

    // Random requests with occasional lock loss.
    for (int it = 0; it < 40; it++) begin
      steps = $urandom_range(0, 7);
      nn    = ($urandom_range(0, 5) == 0) ? 1 : steps;
      span  = SU + PER * nn + 4;
      if ($urandom_range(0, 3) == 0)
        run_req(2'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), 8'(steps),
                $urandom_range(0, span), $urandom_range(1, 6));
      else
        run_req(2'($urandom), 1'($urandom), 1'b0, 8'(steps), -1, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    timeout("global_watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation did not finish");
  end

endmodule
